// File: rtl/decode_queue_pkg.sv
// Shared types and decode constants for the instruction decode queue.
package decode_queue_pkg;

  localparam int unsigned DQ_XLEN = 32;
  localparam int unsigned DQ_ILEN = 32;
  localparam int unsigned DQ_RW   = 5;

  localparam logic [31:0] DQ_NOP    = 32'h0000_0013;
  localparam logic [31:0] DQ_ECALL  = 32'h0000_0073;
  localparam logic [31:0] DQ_EBREAK = 32'h0010_0073;
  localparam logic [31:0] DQ_MRET   = 32'h3020_0073;
  localparam logic [31:0] DQ_WFI    = 32'h1050_0073;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_MISC   = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    CLS_NOP, CLS_ALU, CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_BRANCH,
    CLS_LOAD, CLS_STORE, CLS_MULDIV, CLS_CSR, CLS_SYSTEM, CLS_FENCE, CLS_ILL
  } dq_class_t;

  typedef struct packed {
    logic [DQ_XLEN-1:0] pc;
    logic [DQ_ILEN-1:0] instr;
    dq_class_t          cls;
    logic [DQ_XLEN-1:0] imm;
    logic [DQ_RW-1:0]   rd;
    logic [DQ_RW-1:0]   rs1;
    logic [DQ_RW-1:0]   rs2;
    logic               wren;
    logic               rden1;
    logic               rden2;
    logic               illegal;
  } dq_entry_t;

  function automatic logic [31:0] imm_i(input logic [31:0] i);
    return {{20{i[31]}}, i[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] i);
    return {{20{i[31]}}, i[31:25], i[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] i);
    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] i);
    return {i[31:12], 12'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] i);
    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/decode_queue_predecode_unit.sv
// Combinational RV32IM pre-decoder: raw {pc,instr} -> dq_entry_t.
module predecode_unit
  import decode_queue_pkg::*;
(
  input  logic [DQ_XLEN-1:0] pc,
  input  logic [DQ_ILEN-1:0] instr,
  output dq_entry_t          entry
);

  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic [6:0]         funct7;
  dq_class_t          cls;
  logic [DQ_XLEN-1:0] imm;
  logic               wr;
  logic               r1;
  logic               r2;
  logic               shift_ok;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // Shift-immediates constrain funct7; other OP-IMM funct3 values are all legal.
  always_comb begin
    shift_ok = 1'b1;
    if (funct3 == 3'd1)
      shift_ok = (funct7 == 7'h00);
    else if (funct3 == 3'd5)
      shift_ok = (funct7 == 7'h00) || (funct7 == 7'h20);
  end

  always_comb begin
    cls = CLS_ILL;
    imm = '0;
    wr  = 1'b0;
    r1  = 1'b0;
    r2  = 1'b0;
    case (opcode)
      OPC_LUI:   begin cls = CLS_LUI;   imm = imm_u(instr); wr = 1'b1; end
      OPC_AUIPC: begin cls = CLS_AUIPC; imm = imm_u(instr); wr = 1'b1; end
      OPC_JAL:   begin cls = CLS_JAL;   imm = imm_j(instr); wr = 1'b1; end
      OPC_JALR: begin
        if (funct3 == 3'd0) begin
          cls = CLS_JALR; imm = imm_i(instr); wr = 1'b1; r1 = 1'b1;
        end
      end
      OPC_BRANCH: begin
        if (funct3[2:1] != 2'b01) begin
          cls = CLS_BRANCH; imm = imm_b(instr); r1 = 1'b1; r2 = 1'b1;
        end
      end
      OPC_LOAD: begin
        if (funct3 != 3'd3 && funct3 != 3'd6 && funct3 != 3'd7) begin
          cls = CLS_LOAD; imm = imm_i(instr); wr = 1'b1; r1 = 1'b1;
        end
      end
      OPC_STORE: begin
        if (funct3 < 3'd3) begin
          cls = CLS_STORE; imm = imm_s(instr); r1 = 1'b1; r2 = 1'b1;
        end
      end
      OPC_OPIMM: begin
        if (instr == DQ_NOP) begin
          cls = CLS_NOP;
        end else if (shift_ok) begin
          cls = CLS_ALU; imm = imm_i(instr); wr = 1'b1; r1 = 1'b1;
        end
      end
      OPC_OP: begin
        if (funct7 == 7'h00 ||
            (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5))) begin
          cls = CLS_ALU; wr = 1'b1; r1 = 1'b1; r2 = 1'b1;
        end else if (funct7 == 7'h01) begin
          cls = CLS_MULDIV; wr = 1'b1; r1 = 1'b1; r2 = 1'b1;
        end
      end
      OPC_MISC: begin
        if (funct3[2:1] == 2'b00)
          cls = CLS_FENCE;
      end
      OPC_SYSTEM: begin
        if (funct3 == 3'd0) begin
          if (instr == DQ_ECALL || instr == DQ_EBREAK ||
              instr == DQ_MRET  || instr == DQ_WFI)
            cls = CLS_SYSTEM;
        end else if (funct3 != 3'd4) begin
          // CSR*I forms carry a 5-bit zero-extended immediate in the rs1 slot.
          cls = CLS_CSR;
          wr  = 1'b1;
          if (funct3[2])
            imm = {27'b0, instr[19:15]};
          else
            r1 = 1'b1;
        end
      end
      default: cls = CLS_ILL;
    endcase
  end

  always_comb begin
    entry         = '0;
    entry.pc      = pc;
    entry.instr   = instr;
    entry.cls     = cls;
    entry.imm     = imm;
    entry.rd      = instr[11:7];
    entry.rs1     = instr[19:15];
    entry.rs2     = instr[24:20];
    entry.wren    = wr && (instr[11:7] != 5'd0);
    entry.rden1   = r1;
    entry.rden2   = r2;
    entry.illegal = (cls == CLS_ILL);
  end

endmodule

// File: rtl/decode_queue.sv
// Instruction decode queue: pre-decodes fetch pairs into a circular buffer with flush.
// Optional DECQ_BYPASS_EN presents the incoming entry in the same cycle when empty.
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = DQ_XLEN
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN-1:0]            in_pc,
  input  logic [31:0]                in_instr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [31:0]                out_instr,
  output logic [3:0]                 out_class,
  output logic [XLEN-1:0]            out_imm,
  output logic [4:0]                 out_rd,
  output logic [4:0]                 out_rs1,
  output logic [4:0]                 out_rs2,
  output logic                       out_wren,
  output logic                       out_rden1,
  output logic                       out_rden2,
  output logic                       out_illegal,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  dq_entry_t     mem [DEPTH];
  dq_entry_t     pre;
  dq_entry_t     head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic          bypass;
  logic          stored_valid;

  predecode_unit u_predecode (
    .pc    (in_pc),
    .instr (in_instr),
    .entry (pre)
  );

  assign in_ready     = !reset && !flush && (count < CW'(DEPTH));
  assign stored_valid = (count != '0);

`ifdef DECQ_BYPASS_EN
  assign bypass = !stored_valid && in_valid && !flush && !reset;
`else
  assign bypass = 1'b0;
`endif

  assign out_valid = stored_valid || bypass;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Head is registered storage; a bypassed entry advances both pointers so count stays 0.
  always_comb begin
    head = '0;
    if (stored_valid)
      head = mem[rd_ptr];
    else if (bypass)
      head = pre;
  end

  assign out_pc      = head.pc;
  assign out_instr   = head.instr;
  assign out_class   = head.cls;
  assign out_imm     = head.imm;
  assign out_rd      = head.rd;
  assign out_rs1     = head.rs1;
  assign out_rs2     = head.rs2;
  assign out_wren    = head.wren;
  assign out_rden1   = head.rden1;
  assign out_rden2   = head.rden2;
  assign out_illegal = head.illegal;

  // Pointer/occupancy state; reset and flush both clear the queue.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (push)
      mem[wr_ptr] <= pre;
  end

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: decode vector table plus queue handshake sequences.
module tb_decode_queue;
  import decode_queue_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_pc, in_instr, out_pc, out_instr, out_imm;
  logic [3:0]  out_class;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic        out_wren, out_rden1, out_rden2, out_illegal;
  logic [2:0]  count;

  int          passed = 0;
  int          total  = 0;
  logic [31:0] q[$];
  logic [31:0] next_pc;

  typedef struct {
    logic [31:0] instr;
    dq_class_t   cls;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        wren;
    logic        rden1;
    logic        rden2;
    logic        illegal;
  } vec_t;

  vec_t vecs[13];

  always #5 clock = ~clock;

  decode_queue #(.DEPTH(DEPTH), .XLEN(32)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .out_class(out_class), .out_imm(out_imm), .out_rd(out_rd), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_wren(out_wren), .out_rden1(out_rden1), .out_rden2(out_rden2),
    .out_illegal(out_illegal), .count(count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  // One cycle per iteration against a pc-order queue model.
  task automatic run(input int n, input logic v, input logic r, input logic f);
    logic exp_rdy, do_push, do_pop;
    for (int c = 0; c < n; c++) begin
      in_valid = v; out_ready = r; flush = f;
      in_pc = next_pc; in_instr = 32'h0000_0013;
      #1;
      exp_rdy = !f && (q.size() < DEPTH);
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("count", 32'(count), 32'(q.size()));
      if (q.size() != 0) chk("out_pc", out_pc, q[0]);
      do_push = v && exp_rdy;
      do_pop  = r && (q.size() != 0);
      @(posedge clock); #1;
      if (f) q.delete();
      else begin
        if (do_pop) void'(q.pop_front());
        if (do_push) begin q.push_back(next_pc); next_pc += 32'd4; end
      end
    end
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{32'h0050_0093, CLS_ALU,    32'd5,         5'd1,  5'd0, 5'd5,  1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{32'h0000_007F, CLS_ILL,    32'd0,         5'd0,  5'd0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{32'h0000_0013, CLS_NOP,    32'd0,         5'd0,  5'd0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{32'hFE00_0EE3, CLS_BRANCH, 32'hFFFF_FFFC, 5'd29, 5'd0, 5'd0,  1'b0, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{32'h1234_52B7, CLS_LUI,    32'h1234_5000, 5'd5,  5'd8, 5'd3,  1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{32'h0020_A423, CLS_STORE,  32'd8,         5'd8,  5'd1, 5'd2,  1'b0, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{32'h0220_81B3, CLS_MULDIV, 32'd0,         5'd3,  5'd1, 5'd2,  1'b1, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{32'h0000_0073, CLS_SYSTEM, 32'd0,         5'd0,  5'd0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{32'h3002_E273, CLS_CSR,    32'd5,         5'd4,  5'd5, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{32'h0100_00EF, CLS_JAL,    32'd16,        5'd1,  5'd0, 5'd16, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{32'h8000_0033, CLS_ILL,    32'd0,         5'd0,  5'd0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{32'h0000_3003, CLS_ILL,    32'd0,         5'd0,  5'd0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{32'h0FF0_000F, CLS_FENCE,  32'd0,         5'd0,  5'd0, 5'd31, 1'b0, 1'b0, 1'b0, 1'b0};

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_instr = '0; next_pc = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst in_ready", 32'(in_ready), 32'd0);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst count", 32'(count), 32'd0);
    reset = 1'b0;
    #1;
    chk("post-rst in_ready", 32'(in_ready), 32'd1);
    chk("post-rst out_pc", out_pc, 32'd0);
    chk("post-rst out_imm", out_imm, 32'd0);

    // Single addi with out_ready held high: visible one cycle later, then popped.
    in_valid = 1'b1; in_pc = 32'h100; in_instr = 32'h0050_0093; out_ready = 1'b1;
    #1;
    chk("t1 same-cycle valid", 32'(out_valid), 32'd0);
    @(posedge clock); #1;
    in_valid = 1'b0;
    chk("t1 out_valid", 32'(out_valid), 32'd1);
    chk("t1 count", 32'(count), 32'd1);
    chk("t1 out_pc", out_pc, 32'h100);
    chk("t1 class", 32'(out_class), 32'(CLS_ALU));
    chk("t1 imm", out_imm, 32'd5);
    chk("t1 rd", 32'(out_rd), 32'd1);
    chk("t1 wren", 32'(out_wren), 32'd1);
    chk("t1 rden1", 32'(out_rden1), 32'd1);
    @(posedge clock); #1;
    out_ready = 1'b0;
    chk("t1 count after pop", 32'(count), 32'd0);
    chk("t1 out_valid after pop", 32'(out_valid), 32'd0);

    // Decode table.
    for (int i = 0; i < 13; i++) begin
      in_valid = 1'b1; in_pc = 32'h1000 + 32'(i * 4); in_instr = vecs[i].instr;
      @(posedge clock); #1;
      in_valid = 1'b0;
      chk($sformatf("v%0d valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("v%0d pc", i), out_pc, 32'h1000 + 32'(i * 4));
      chk($sformatf("v%0d instr", i), out_instr, vecs[i].instr);
      chk($sformatf("v%0d class", i), 32'(out_class), 32'(vecs[i].cls));
      chk($sformatf("v%0d imm", i), out_imm, vecs[i].imm);
      chk($sformatf("v%0d rd", i), 32'(out_rd), 32'(vecs[i].rd));
      chk($sformatf("v%0d rs1", i), 32'(out_rs1), 32'(vecs[i].rs1));
      chk($sformatf("v%0d rs2", i), 32'(out_rs2), 32'(vecs[i].rs2));
      chk($sformatf("v%0d wren", i), 32'(out_wren), 32'(vecs[i].wren));
      chk($sformatf("v%0d rden1", i), 32'(out_rden1), 32'(vecs[i].rden1));
      chk($sformatf("v%0d rden2", i), 32'(out_rden2), 32'(vecs[i].rden2));
      chk($sformatf("v%0d illegal", i), 32'(out_illegal), 32'(vecs[i].illegal));
      out_ready = 1'b1;
      @(posedge clock); #1;
      out_ready = 1'b0;
      chk($sformatf("v%0d drained", i), 32'(count), 32'd0);
    end

    // Fill to DEPTH, reject an extra push, drain in order.
    next_pc = 32'h200;
    run(DEPTH, 1'b1, 1'b0, 1'b0);
    run(1, 1'b1, 1'b0, 1'b0);
    run(DEPTH, 1'b0, 1'b1, 1'b0);
    run(1, 1'b0, 1'b0, 1'b0);

    // Steady streaming from full so both pointers wrap several times.
    next_pc = 32'h400;
    run(DEPTH, 1'b1, 1'b0, 1'b0);
    run(3 * DEPTH, 1'b1, 1'b1, 1'b0);
    run(DEPTH + 2, 1'b0, 1'b1, 1'b0);

    // Flush with three entries and a simultaneous push.
    next_pc = 32'h600;
    run(3, 1'b1, 1'b0, 1'b0);
    run(1, 1'b1, 1'b1, 1'b1);
    chk("flush count", 32'(count), 32'd0);
    chk("flush out_valid", 32'(out_valid), 32'd0);
    chk("flush out_pc", out_pc, 32'd0);
    run(2, 1'b1, 1'b1, 1'b0);
    run(2, 1'b0, 1'b1, 1'b0);

    // Reset mid-stream with entries held.
    next_pc = 32'h800;
    run(2, 1'b1, 1'b0, 1'b0);
    reset = 1'b1; in_valid = 1'b1; in_instr = 32'hFE00_0EE3;
    #1;
    chk("mid-rst in_ready", 32'(in_ready), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0; in_valid = 1'b0;
    q.delete();
    #1;
    chk("mid-rst count", 32'(count), 32'd0);
    chk("mid-rst out_valid", 32'(out_valid), 32'd0);
    chk("mid-rst out_pc", out_pc, 32'd0);
    chk("mid-rst out_instr", out_instr, 32'd0);
    chk("mid-rst out_imm", out_imm, 32'd0);
    chk("mid-rst out_class", 32'(out_class), 32'd0);
    chk("mid-rst out_rd", 32'(out_rd), 32'd0);
    chk("mid-rst out_rden1", 32'(out_rden1), 32'd0);
    run(2, 1'b1, 1'b1, 1'b0);
    run(2, 1'b0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
